// File: rtl/mole_spawner_pkg.sv
// Shared types and helpers for the mole spawner: FSM states, board geometry,
// and the hole-index selection used when a new mole pops up.
package mole_spawner_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      GAP  = 2'd1,
      SHOW = 2'd2,
      OVER = 2'd3
   } state_t;

   localparam int NUM_HOLES = 10;
   localparam int POSIT_W   = 10;
   localparam int IDX_W     = 4;

   // Galois feedback mask for x^16 + x^14 + x^13 + x^11 + 1 (right-shifting form)
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   function automatic logic [POSIT_W-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
      logic [POSIT_W-1:0] oh;
      oh = '0;
      for (int i = 0; i < POSIT_W; i++) begin
         if (idx == IDX_W'(i)) oh[i] = 1'b1;
      end
      return oh;
   endfunction

   // Folds the low nibble onto 0..9 and steps past the previous hole so the
   // same hole never appears twice in a row.
   function automatic logic [IDX_W-1:0] pick_index(input logic [15:0] lfsr,
                                                    input logic [IDX_W-1:0] prev);
      logic [IDX_W-1:0] idx;
      idx = (lfsr[3:0] < 4'd10) ? lfsr[3:0] : lfsr[3:0] - 4'd6;
      if (idx == prev) begin
         idx = (idx == IDX_W'(NUM_HOLES - 1)) ? '0 : idx + 4'd1;
      end
      return idx;
   endfunction

endpackage

// File: rtl/mole_spawner_lfsr16.sv
// 16-bit Galois LFSR that free-runs every clock; a zero seed is forced to 1 so
// the register can never lock up in the all-zero state.
module lfsr16
   import mole_spawner_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] seed,
   output logic [15:0] q
);

   logic [15:0] q_reg;
   logic [15:0] q_next;
   logic [15:0] seed_safe;

   assign seed_safe = (seed == 16'h0000) ? 16'h0001 : seed;

   generate
      for (genvar gi = 0; gi < 16; gi++) begin : g_tap
         if (gi == 15) begin : g_top
            assign q_next[gi] = LFSR_TAPS[gi] & q_reg[0];
         end else begin : g_mid
            assign q_next[gi] = q_reg[gi+1] ^ (LFSR_TAPS[gi] & q_reg[0]);
         end
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         q_reg <= seed_safe;
      end else begin
         q_reg <= q_next;
      end
   end

   assign q = q_reg;

endmodule

// File: rtl/mole_spawner.sv
// Whack-a-mole game core: shows a mole at a pseudo-random hole for a fixed
// window, scores matching whacks, counts timeouts and ends the game on too many.
module mole_spawner
   import mole_spawner_pkg::*;
#(
   parameter int          SHOW_CYCLES = 50_000_000,
   parameter int          GAP_CYCLES  = 25_000_000,
   parameter int          MAX_MISSES  = 5,
   parameter int          SCORE_W     = 8,
   parameter logic [15:0] LFSR_SEED   = 16'hACE1
)(
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               whack,
   input  logic [POSIT_W-1:0] board_posit,
   output logic [POSIT_W-1:0] mole_posit,
   output logic               mole_valid,
   output logic [SCORE_W-1:0] score,
   output logic [3:0]         misses,
   output logic               hit_pulse,
   output logic               miss_pulse,
   output logic               game_over
);

   localparam int TIMER_MAX = (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
   localparam int TIMER_W   = $clog2(TIMER_MAX);

   localparam logic [TIMER_W-1:0] SHOW_LAST  = TIMER_W'(SHOW_CYCLES - 1);
   localparam logic [TIMER_W-1:0] GAP_LAST   = TIMER_W'(GAP_CYCLES - 1);
   localparam logic [3:0]         MISS_LIMIT = 4'(MAX_MISSES);
   localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;

   state_t             state_reg,  state_next;
   logic [TIMER_W-1:0] timer_reg,  timer_next;
   logic [SCORE_W-1:0] score_reg,  score_next;
   logic [3:0]         misses_reg, misses_next;
   logic [POSIT_W-1:0] mole_reg,   mole_next;
   logic [IDX_W-1:0]   prev_idx_reg, prev_idx_next;
   logic               hit_reg,    hit_next;
   logic               miss_reg,   miss_next;

   logic [15:0]        lfsr_q;
   logic [IDX_W-1:0]   sel_idx;
   logic               is_hit;
   logic               show_done;
   logic               gap_done;
   logic [3:0]         misses_inc;
   logic               miss_final;

   lfsr16 u_lfsr (
      .clk  (clk),
      .rst  (rst),
      .seed (LFSR_SEED),
      .q    (lfsr_q)
   );

   // mole_reg is one-hot while showing, so zero or multi-hot positions never match
   assign is_hit     = (state_reg == SHOW) && whack && (board_posit == mole_reg);
   assign show_done  = (timer_reg == SHOW_LAST);
   assign gap_done   = (timer_reg == GAP_LAST);
   assign misses_inc = misses_reg + 4'd1;
   assign miss_final = (misses_inc == MISS_LIMIT);
   assign sel_idx    = pick_index(lfsr_q, prev_idx_reg);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (start) state_next = GAP;
         GAP:     if (gap_done) state_next = SHOW;
         SHOW: begin
            if (is_hit) begin
               state_next = GAP;
            end else if (show_done) begin
               state_next = miss_final ? OVER : GAP;
            end
         end
         OVER:    if (start) state_next = GAP;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      timer_next    = timer_reg;
      score_next    = score_reg;
      misses_next   = misses_reg;
      mole_next     = mole_reg;
      prev_idx_next = prev_idx_reg;
      hit_next      = 1'b0;
      miss_next     = 1'b0;
      case (state_reg)
         IDLE, OVER: begin
            if (start) begin
               timer_next  = '0;
               score_next  = '0;
               misses_next = '0;
            end
         end
         GAP: begin
            if (gap_done) begin
               timer_next    = '0;
               mole_next     = idx_to_onehot(sel_idx);
               prev_idx_next = sel_idx;
            end else begin
               timer_next = timer_reg + 1'b1;
            end
         end
         SHOW: begin
            // A hit on the final count takes priority over the timeout
            if (is_hit) begin
               timer_next = '0;
               mole_next  = '0;
               hit_next   = 1'b1;
               if (score_reg != SCORE_MAX) score_next = score_reg + 1'b1;
            end else if (show_done) begin
               timer_next  = '0;
               mole_next   = '0;
               miss_next   = 1'b1;
               misses_next = misses_inc;
            end else begin
               timer_next = timer_reg + 1'b1;
            end
         end
         default: begin
            timer_next = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         timer_reg    <= '0;
         score_reg    <= '0;
         misses_reg   <= '0;
         mole_reg     <= '0;
         prev_idx_reg <= '0;
         hit_reg      <= 1'b0;
         miss_reg     <= 1'b0;
      end else begin
         timer_reg    <= timer_next;
         score_reg    <= score_next;
         misses_reg   <= misses_next;
         mole_reg     <= mole_next;
         prev_idx_reg <= prev_idx_next;
         hit_reg      <= hit_next;
         miss_reg     <= miss_next;
      end
   end

   always_comb begin
      mole_posit = mole_reg;
      mole_valid = (state_reg == SHOW);
      game_over  = (state_reg == OVER);
      score      = score_reg;
      misses     = misses_reg;
      hit_pulse  = hit_reg;
      miss_pulse = miss_reg;
   end

endmodule

// File: tb/tb_mole_spawner.sv
// Directed bench for mole_spawner with a phase/countdown reference model
// checked against the DUT every cycle, plus hand-derived timing expectations.
module tb_mole_spawner;

   localparam int SHOW_N = 8;
   localparam int GAP_N  = 4;
   localparam int MAXM   = 3;
   localparam int SW     = 2;
   localparam int SMAX   = (1 << SW) - 1;

   localparam int P_IDLE = 0;
   localparam int P_GAP  = 1;
   localparam int P_SHOW = 2;
   localparam int P_OVER = 3;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic          whack = 1'b0;
   logic [9:0]    board_posit = '0;
   logic [9:0]    mole_posit;
   logic          mole_valid;
   logic [SW-1:0] score;
   logic [3:0]    misses;
   logic          hit_pulse;
   logic          miss_pulse;
   logic          game_over;

   int n_checks = 0;
   int n_fail   = 0;

   // reference model state
   bit          m_armed = 1'b0;
   int          m_phase;
   int          m_left;
   logic [15:0] m_lfsr;
   int          m_prev;
   logic [9:0]  m_mole;
   int          m_score;
   int          m_misses;
   bit          m_hit;
   bit          m_miss;

   always #5 clk = ~clk;

   mole_spawner #(
      .SHOW_CYCLES (SHOW_N),
      .GAP_CYCLES  (GAP_N),
      .MAX_MISSES  (MAXM),
      .SCORE_W     (SW),
      .LFSR_SEED   (16'hACE1)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .whack       (whack),
      .board_posit (board_posit),
      .mole_posit  (mole_posit),
      .mole_valid  (mole_valid),
      .score       (score),
      .misses      (misses),
      .hit_pulse   (hit_pulse),
      .miss_pulse  (miss_pulse),
      .game_over   (game_over)
   );

   task automatic check(input string name, input int actual, input int expected);
      n_checks++;
      if (actual != expected) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
      end
   endtask

   function automatic logic [15:0] lfsr_step(input logic [15:0] v);
      return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
   endfunction

   always @(posedge clk) begin : model
      logic [15:0] cur;
      int idx;
      m_hit  = 1'b0;
      m_miss = 1'b0;
      if (rst) begin
         m_armed  = 1'b1;
         m_phase  = P_IDLE;
         m_left   = 0;
         m_lfsr   = 16'hACE1;
         m_prev   = 0;
         m_mole   = '0;
         m_score  = 0;
         m_misses = 0;
      end else begin
         cur    = m_lfsr;
         m_lfsr = lfsr_step(m_lfsr);
         case (m_phase)
            P_IDLE, P_OVER: begin
               if (start) begin
                  m_phase  = P_GAP;
                  m_left   = GAP_N;
                  m_score  = 0;
                  m_misses = 0;
               end
            end
            P_GAP: begin
               m_left--;
               if (m_left == 0) begin
                  idx = int'(cur[3:0]);
                  if (idx >= 10) idx -= 6;
                  if (idx == m_prev) idx = (idx + 1) % 10;
                  m_prev  = idx;
                  m_mole  = 10'b1 << idx;
                  m_phase = P_SHOW;
                  m_left  = SHOW_N;
               end
            end
            default: begin
               if (whack && board_posit == m_mole) begin
                  m_hit   = 1'b1;
                  m_score = (m_score == SMAX) ? SMAX : m_score + 1;
                  m_mole  = '0;
                  m_phase = P_GAP;
                  m_left  = GAP_N;
               end else begin
                  m_left--;
                  if (m_left == 0) begin
                     m_miss = 1'b1;
                     m_misses++;
                     m_mole  = '0;
                     m_phase = (m_misses == MAXM) ? P_OVER : P_GAP;
                     m_left  = GAP_N;
                  end
               end
            end
         endcase
      end
   end

   always @(posedge clk) begin
      #1;
      if (m_armed) begin
         check("model_mole_posit", int'(mole_posit), int'(m_mole));
         check("model_mole_valid", int'(mole_valid), int'(m_phase == P_SHOW));
         check("model_game_over", int'(game_over), int'(m_phase == P_OVER));
         check("model_score", int'(score), m_score);
         check("model_misses", int'(misses), m_misses);
         check("model_hit_pulse", int'(hit_pulse), int'(m_hit));
         check("model_miss_pulse", int'(miss_pulse), int'(m_miss));
         check("pulse_exclusive", int'(hit_pulse & miss_pulse), 0);
      end
   end

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_mole();
      int k = 0;
      while (!mole_valid && k < 64) begin
         @(negedge clk);
         k++;
      end
      check("wait_mole_in_budget", int'(mole_valid), 1);
   endtask

   // returns cycles from mole appearance (c_in) until miss_pulse is seen
   task automatic wait_miss(input int c_in, output int c_out);
      int c = c_in;
      while (!miss_pulse && c < 64) begin
         @(negedge clk);
         c++;
      end
      c_out = c;
   endtask

   task automatic do_hit(input logic [9:0] pos);
      board_posit = pos;
      whack = 1'b1;
      @(negedge clk);
      whack = 1'b0;
      board_posit = '0;
   endtask

   initial begin
      #200_000;
      $display("FAIL watchdog: simulation still running, required finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int c;
      logic [9:0] seen;
      logic [9:0] prev;

      // reset and idle
      repeat (3) @(negedge clk);
      check("reset_mole_posit", int'(mole_posit), 0);
      check("reset_mole_valid", int'(mole_valid), 0);
      check("reset_score", int'(score), 0);
      check("reset_misses", int'(misses), 0);
      check("reset_game_over", int'(game_over), 0);
      rst = 1'b0;
      repeat (20) @(negedge clk);
      check("idle_mole_valid", int'(mole_valid), 0);
      check("idle_mole_posit", int'(mole_posit), 0);
      check("idle_game_over", int'(game_over), 0);

      // basic hit and gap length
      pulse_start();
      wait_mole();
      seen = mole_posit;
      check("first_mole_onehot", $countones(seen), 1);
      do_hit(seen);
      check("hit_pulse_basic", int'(hit_pulse), 1);
      check("hit_score_1", int'(score), 1);
      check("hit_clears_mole", int'(mole_posit), 0);
      c = 0;
      while (!mole_valid && c < 64) begin
         @(negedge clk);
         c++;
      end
      check("hit_to_next_mole_cycles", c, 4);

      // wrong position: rotated by one, no penalty, then timeout
      seen = mole_posit;
      do_hit({seen[8:0], seen[9]});
      check("wrong_no_hit", int'(hit_pulse), 0);
      check("wrong_score_kept", int'(score), 1);
      wait_miss(1, c);
      check("show_to_miss_cycles", c, 8);
      check("wrong_then_miss_1", int'(misses), 1);

      // matching whack on the last show count
      wait_mole();
      repeat (7) @(negedge clk);
      check("edge_still_showing", int'(mole_valid), 1);
      do_hit(mole_posit);
      check("edge_hit_pulse", int'(hit_pulse), 1);
      check("edge_no_miss", int'(miss_pulse), 0);
      check("edge_misses_kept", int'(misses), 1);
      check("edge_score_2", int'(score), 2);

      // start and whack during GAP are ignored
      pulse_start();
      do_hit(10'h001);
      check("gap_start_ignored_score", int'(score), 2);

      // run out the remaining misses to reach OVER
      for (int i = 2; i <= MAXM; i++) begin
         wait_mole();
         wait_miss(0, c);
         check("miss_cycles", c, 8);
         check("miss_count_step", int'(misses), i);
      end
      check("over_after_last_miss", int'(game_over), 1);
      repeat (5) @(negedge clk);
      check("over_holds", int'(game_over), 1);
      check("over_mole_zero", int'(mole_posit), 0);
      check("over_misses_held", int'(misses), MAXM);
      check("over_score_held", int'(score), 2);

      // fresh game, misses step 1,2,3
      pulse_start();
      check("restart_misses_clear", int'(misses), 0);
      check("restart_score_clear", int'(score), 0);
      for (int i = 1; i <= MAXM; i++) begin
         wait_mole();
         wait_miss(0, c);
         check("miss_cycles_fresh", c, 8);
         check("miss_count_fresh", int'(misses), i);
      end
      check("over_fresh", int'(game_over), 1);

      // position legality over 200 moles, score saturation
      pulse_start();
      prev = '0;
      for (int i = 0; i < 200; i++) begin
         wait_mole();
         seen = mole_posit;
         check("mole_onehot", $countones(seen), 1);
         if (i > 0) check("mole_differs_from_prev", int'(seen != prev), 1);
         prev = seen;
         do_hit(seen);
         check("legality_hit_pulse", int'(hit_pulse), 1);
         if (i == 3) check("score_saturates", int'(score), 3);
      end
      check("score_saturated_end", int'(score), 3);

      // reset mid-SHOW
      wait_mole();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("rst_mid_show_mole", int'(mole_posit), 0);
      check("rst_mid_show_valid", int'(mole_valid), 0);
      check("rst_mid_show_score", int'(score), 0);
      check("rst_mid_show_misses", int'(misses), 0);
      check("rst_mid_show_hit", int'(hit_pulse), 0);
      check("rst_mid_show_miss", int'(miss_pulse), 0);
      rst = 1'b0;
      repeat (10) @(negedge clk);
      check("post_rst_idle", int'(mole_valid), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
